// File: rtl/onehot_decoder_pkg.sv
// -----------------------------------------------------------------------------
// onehot_decoder_pkg
//   Shared types and constants for the streaming index-to-mask decoder.
//   - dec_state_t : frame state (IDLE = no partial frame, ACCUM = partial frame)
//   - ERR_CNT_W   : width of the saturating out-of-range beat counter
//   - FIFO_DEPTH  : number of completed masks buffered toward the consumer
// -----------------------------------------------------------------------------
package onehot_decoder_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    ACCUM = 1'b1
  } dec_state_t;

  localparam int ERR_CNT_W  = 8;
  localparam int FIFO_DEPTH = 2;

  // Saturation ceiling of the error counter (all ones).
  localparam logic [ERR_CNT_W-1:0] ERR_CNT_MAX = '1;

  // Index width for a given mask width; never narrower than one bit.
  function automatic int index_width(input int width);
    return (width > 1) ? $clog2(width) : 1;
  endfunction

endpackage

// File: rtl/onehot_decoder_if.sv
// -----------------------------------------------------------------------------
// onehot_decoder_if
//   Bundles the input beat stream and the output mask stream of the decoder.
//
//   Handshake rule for both streams: a transfer happens on a rising clock edge
//   where valid and ready are both high. The sender keeps valid and its payload
//   stable until the transfer happens; ready never depends combinationally on
//   valid.
//
//   Signals:
//     in_valid / in_ready / in_index / in_last : producer -> decoder beats
//     out_valid / out_ready / out_mask / out_err : decoder -> consumer masks
//   Modports:
//     master : the surrounding logic (drives beats, accepts masks)
//     slave  : the decoder itself
// -----------------------------------------------------------------------------
interface onehot_decoder_if #(
  parameter int decoderWidth = 16
);
  import onehot_decoder_pkg::*;

  localparam int IW = index_width(decoderWidth);

  logic                    in_valid;
  logic                    in_ready;
  logic [IW-1:0]           in_index;
  logic                    in_last;
  logic                    out_valid;
  logic                    out_ready;
  logic [decoderWidth-1:0] out_mask;
  logic                    out_err;

  modport master (
    output in_valid, in_index, in_last, out_ready,
    input  in_ready, out_valid, out_mask, out_err
  );

  modport slave (
    input  in_valid, in_index, in_last, out_ready,
    output in_ready, out_valid, out_mask, out_err
  );

endinterface

// File: rtl/onehot_decoder_mask_fifo.sv
// -----------------------------------------------------------------------------
// mask_fifo
//   Two-entry synchronous FIFO holding completed {err, mask} words.
//
//   Ports:
//     clk, rst     : clock, asynchronous active-high reset (empties the FIFO)
//     clk_en       : when low, nothing in the FIFO changes
//     push_i       : write push_data_i at the tail (caller guarantees not full)
//     push_data_i  : word to write
//     pop_i        : drop the head entry (caller guarantees not empty)
//     count_o      : number of valid entries, 0..FIFO_DEPTH
//     head_o       : head entry, or all zeros when empty
// -----------------------------------------------------------------------------
module mask_fifo
  import onehot_decoder_pkg::*;
#(
  parameter int W = 17
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clk_en,
  input  logic         push_i,
  input  logic [W-1:0] push_data_i,
  input  logic         pop_i,
  output logic [1:0]   count_o,
  output logic [W-1:0] head_o
);

  logic [W-1:0] mem_q [FIFO_DEPTH];
  logic         wr_ptr_q, wr_ptr_d;
  logic         rd_ptr_q, rd_ptr_d;
  logic [1:0]   count_q, count_d;

  // With a depth of two the pointers are single bits that simply toggle.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push_i) begin
      wr_ptr_d = ~wr_ptr_q;
    end
    if (pop_i) begin
      rd_ptr_d = ~rd_ptr_q;
    end
    // Simultaneous push and pop leave the occupancy unchanged.
    if (push_i && !pop_i) begin
      count_d = count_q + 2'd1;
    end else if (pop_i && !push_i) begin
      count_d = count_q - 2'd1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        mem_q[i] <= '0;
      end
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      count_q  <= 2'd0;
    end else if (clk_en) begin
      if (push_i) begin
        mem_q[wr_ptr_q] <= push_data_i;
      end
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  assign count_o = count_q;
  assign head_o  = (count_q != 2'd0) ? mem_q[rd_ptr_q] : '0;

endmodule

// File: rtl/onehot_decoder.sv
// -----------------------------------------------------------------------------
// onehot_decoder
//   Streaming index-to-mask decoder. Each accepted beat carries a bit index;
//   the decoded one-hot bit is ORed into a frame accumulator. A beat with
//   in_last closes the frame and pushes {err, mask} into a two-entry FIFO that
//   feeds the consumer. Indices at or above decoderWidth contribute nothing to
//   the mask, mark the frame as erroneous and bump a saturating counter.
//
//   Ports:
//     clk, rst     : clock, asynchronous active-high reset
//     clk_en       : clock enable; when low all state holds and no transfer
//                    happens on either stream
//     bus          : onehot_decoder_if slave (beat input, mask output)
//     err_count    : saturating count of out-of-range beats
//     frame_active : high while a partial frame sits in the accumulator
//                    (this is also the state machine's visible state)
// -----------------------------------------------------------------------------
module onehot_decoder
  import onehot_decoder_pkg::*;
#(
  parameter int decoderWidth = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 clk_en,
  onehot_decoder_if.slave      bus,
  output logic [ERR_CNT_W-1:0] err_count,
  output logic                 frame_active
);

  localparam int IW = index_width(decoderWidth);
  localparam int DW = decoderWidth + 1;
  localparam logic [31:0] WIDTH_U = decoderWidth;

  dec_state_t              state_q, state_d;
  logic [decoderWidth-1:0] acc_q, acc_d;
  logic                    err_flag_q, err_flag_d;
  logic [ERR_CNT_W-1:0]    err_cnt_q, err_cnt_d;

  logic                    in_ready_w;
  logic                    out_valid_w;
  logic                    accept;
  logic                    pop;
  logic                    in_range;
  logic                    bad;
  logic [decoderWidth-1:0] dec;
  logic                    push;
  logic [DW-1:0]           push_data;
  logic [1:0]              fifo_count;
  logic [DW-1:0]           fifo_head;

  // Ready/valid come only from the registered occupancy and clk_en. in_ready
  // is also held low while reset is asserted so the whole output set reads
  // zero during reset.
  assign in_ready_w  = clk_en & ~rst & (fifo_count != 2'(FIFO_DEPTH));
  assign out_valid_w = clk_en & (fifo_count != 2'd0);
  assign accept      = bus.in_valid & in_ready_w;
  assign pop         = out_valid_w & bus.out_ready;

  // When decoderWidth is not a power of two the index field can name bits
  // that do not exist; those beats are flagged rather than wrapped.
  assign in_range = ({{(32-IW){1'b0}}, bus.in_index} < WIDTH_U);
  assign bad      = ~in_range;

  always_comb begin
    dec = '0;
    for (int i = 0; i < decoderWidth; i++) begin
      dec[i] = in_range && (bus.in_index == IW'(i));
    end
  end

  always_comb begin
    state_d    = state_q;
    acc_d      = acc_q;
    err_flag_d = err_flag_q;
    err_cnt_d  = err_cnt_q;
    push       = 1'b0;
    push_data  = '0;
    if (accept) begin
      if (bad && (err_cnt_q != ERR_CNT_MAX)) begin
        err_cnt_d = err_cnt_q + 1'b1;
      end
      case (state_q)
        IDLE: begin
          if (bus.in_last) begin
            // Single-beat frame goes straight to the FIFO; the accumulator
            // is already clear in IDLE.
            push      = 1'b1;
            push_data = {bad, dec};
          end else begin
            acc_d      = dec;
            err_flag_d = bad;
            state_d    = ACCUM;
          end
        end
        ACCUM: begin
          if (bus.in_last) begin
            push       = 1'b1;
            push_data  = {err_flag_q | bad, acc_q | dec};
            acc_d      = '0;
            err_flag_d = 1'b0;
            state_d    = IDLE;
          end else begin
            acc_d      = acc_q | dec;
            err_flag_d = err_flag_q | bad;
          end
        end
        default: begin
          state_d = IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      acc_q      <= '0;
      err_flag_q <= 1'b0;
      err_cnt_q  <= '0;
    end else if (clk_en) begin
      state_q    <= state_d;
      acc_q      <= acc_d;
      err_flag_q <= err_flag_d;
      err_cnt_q  <= err_cnt_d;
    end
  end

  mask_fifo #(
    .W (DW)
  ) u_fifo (
    .clk         (clk),
    .rst         (rst),
    .clk_en      (clk_en),
    .push_i      (push),
    .push_data_i (push_data),
    .pop_i       (pop),
    .count_o     (fifo_count),
    .head_o      (fifo_head)
  );

  assign bus.in_ready  = in_ready_w;
  assign bus.out_valid = out_valid_w;
  assign bus.out_mask  = fifo_head[decoderWidth-1:0];
  assign bus.out_err   = fifo_head[DW-1];
  assign err_count     = err_cnt_q;
  assign frame_active  = (state_q == ACCUM);

endmodule

// File: tb/tb_onehot_decoder.sv
module tb_onehot_decoder;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst;
  logic clk_en;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // sel = 0 drives the 16-wide instance, sel = 1 the 12-wide instance
  logic       sel;
  logic       d_valid, d_last, d_oready;
  logic [3:0] d_index;

  onehot_decoder_if #(.decoderWidth(16)) b16 ();
  onehot_decoder_if #(.decoderWidth(12)) b12 ();
  logic [7:0] ec16, ec12;
  logic       fa16, fa12;

  assign b16.in_valid  = ~sel & d_valid;
  assign b16.in_index  = d_index;
  assign b16.in_last   = d_last;
  assign b16.out_ready = ~sel & d_oready;
  assign b12.in_valid  = sel & d_valid;
  assign b12.in_index  = d_index;
  assign b12.in_last   = d_last;
  assign b12.out_ready = sel & d_oready;

  onehot_decoder #(.decoderWidth(16)) u16 (
    .clk(clk), .rst(rst), .clk_en(clk_en), .bus(b16),
    .err_count(ec16), .frame_active(fa16)
  );
  onehot_decoder #(.decoderWidth(12)) u12 (
    .clk(clk), .rst(rst), .clk_en(clk_en), .bus(b12),
    .err_count(ec12), .frame_active(fa12)
  );

  // observed outputs of the selected instance
  logic        o_ready, o_valid, o_err, o_active;
  logic [15:0] o_mask;
  logic [7:0]  o_errcnt;
  assign o_ready  = sel ? b12.in_ready  : b16.in_ready;
  assign o_valid  = sel ? b12.out_valid : b16.out_valid;
  assign o_mask   = sel ? {4'b0, b12.out_mask} : b16.out_mask;
  assign o_err    = sel ? b12.out_err   : b16.out_err;
  assign o_active = sel ? fa12 : fa16;
  assign o_errcnt = sel ? ec12 : ec16;

  // ---------------- reference model ----------------
  // exp_q holds completed frames not yet taken by the consumer: {err, mask}
  logic [16:0] exp_q[$];
  logic [15:0] m_acc;
  logic        m_err;
  logic        m_active;
  int          m_cnt[2];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    exp_q.delete();
    m_acc    = '0;
    m_err    = 1'b0;
    m_active = 1'b0;
    m_cnt[0] = 0;
    m_cnt[1] = 0;
  endtask

  task automatic model_beat(input logic [3:0] idx, input logic last);
    int          wd;
    logic        bad;
    logic [15:0] dbit;
    wd   = sel ? 12 : 16;
    bad  = (int'(idx) >= wd);
    dbit = bad ? 16'd0 : (16'd1 << idx);
    if (bad && m_cnt[int'(sel)] < 255) m_cnt[int'(sel)]++;
    m_acc = m_acc | dbit;
    m_err = m_err | bad;
    if (last) begin
      exp_q.push_back({m_err, m_acc});
      m_acc    = '0;
      m_err    = 1'b0;
      m_active = 1'b0;
    end else begin
      m_active = 1'b1;
    end
  endtask

  task automatic check_outputs(input string tag);
    logic [16:0] head;
    head = (exp_q.size() > 0) ? exp_q[0] : 17'd0;
    chk({tag, " in_ready"},     32'(o_ready),  32'(clk_en & ~rst & (exp_q.size() < 2)));
    chk({tag, " out_valid"},    32'(o_valid),  32'(clk_en & (exp_q.size() > 0)));
    chk({tag, " out_mask"},     32'(o_mask),   32'(head[15:0]));
    chk({tag, " out_err"},      32'(o_err),    32'(head[16]));
    chk({tag, " frame_active"}, 32'(o_active), 32'(m_active));
    chk({tag, " err_count"},    32'(o_errcnt), 32'(m_cnt[int'(sel)]));
  endtask

  // ---------------- driver ----------------
  // One clock: drive, predict the transfers from the model, update at the
  // edge, check at the following falling edge.
  task automatic cycle(input logic v, input logic [3:0] idx, input logic last, input logic ordy);
    logic acc, pop;
    d_valid  = v;
    d_index  = idx;
    d_last   = last;
    d_oready = ordy;
    acc = v & clk_en & (exp_q.size() < 2);
    pop = clk_en & (exp_q.size() > 0) & ordy;
    @(posedge clk);
    if (pop) void'(exp_q.pop_front());
    if (acc) model_beat(idx, last);
    @(negedge clk);
    check_outputs("cyc");
    d_valid = 1'b0;
  endtask

  task automatic drain(input string tag);
    for (int k = 0; k < 20 && (m_active || exp_q.size() > 0); k++) begin
      clk_en = 1'b1;
      cycle(m_active, 4'd0, 1'b1, 1'b1);
    end
    chk({tag, " drained valid"},  32'(o_valid),  32'd0);
    chk({tag, " drained active"}, 32'(o_active), 32'd0);
  endtask

  // Reset asserted between edges; outputs must clear without a clock edge.
  task automatic async_reset();
    #2 rst = 1'b1;
    #1 model_reset();
    check_outputs("async_rst");
    chk("async_rst ready_low", 32'(o_ready), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    #1 check_outputs("rst_release");
  endtask

  // ---------------- vectors ----------------
  typedef struct {
    logic [3:0]  idx;
    logic        last;
    logic [15:0] mask;
    logic        err;
  } vec_t;
  vec_t tbl[3];

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [3:0] ri;
    logic       rv, rl, ro;

    rst = 1'b1; clk_en = 1'b1; sel = 1'b0;
    d_valid = 1'b0; d_index = '0; d_last = 1'b0; d_oready = 1'b0;
    model_reset();
    #1 check_outputs("reset16");
    sel = 1'b1;
    #1 check_outputs("reset12");
    sel = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    #1 check_outputs("out_of_reset");
    @(negedge clk);

    // single-beat frames, one cycle latency, consumer always ready
    tbl[0] = '{idx: 4'd0,  last: 1'b1, mask: 16'h0001, err: 1'b0};
    tbl[1] = '{idx: 4'd7,  last: 1'b1, mask: 16'h0080, err: 1'b0};
    tbl[2] = '{idx: 4'd15, last: 1'b1, mask: 16'h8000, err: 1'b0};
    for (int i = 0; i < 3; i++) begin
      cycle(1'b1, tbl[i].idx, tbl[i].last, 1'b1);
      chk("tbl out_valid", 32'(o_valid), 32'd1);
      chk("tbl out_mask",  32'(o_mask),  32'(tbl[i].mask));
      chk("tbl out_err",   32'(o_err),   32'(tbl[i].err));
    end
    drain("tbl");

    // multi-beat frame with a duplicate index
    cycle(1'b1, 4'd3, 1'b0, 1'b1);
    chk("multi active1", 32'(o_active), 32'd1);
    cycle(1'b1, 4'd5, 1'b0, 1'b1);
    cycle(1'b1, 4'd3, 1'b0, 1'b1);
    chk("multi active3", 32'(o_active), 32'd1);
    chk("multi no_out",  32'(o_valid),  32'd0);
    cycle(1'b1, 4'd9, 1'b1, 1'b1);
    chk("multi mask",    32'(o_mask),   32'h0228);
    chk("multi active0", 32'(o_active), 32'd0);
    drain("multi");

    // backpressure: FIFO fills, drains in order, third frame follows
    cycle(1'b1, 4'd1, 1'b1, 1'b0);
    cycle(1'b1, 4'd2, 1'b1, 1'b0);
    chk("bp full ready", 32'(o_ready), 32'd0);
    cycle(1'b1, 4'd3, 1'b1, 1'b0);
    chk("bp stall ready", 32'(o_ready), 32'd0);
    chk("bp head1", 32'(o_mask), 32'h0002);
    cycle(1'b1, 4'd3, 1'b1, 1'b1);
    chk("bp head2", 32'(o_mask), 32'h0004);
    cycle(1'b1, 4'd3, 1'b1, 1'b1);
    chk("bp head3", 32'(o_mask), 32'h0008);
    drain("bp");

    // clock enable low mid-frame with the beat held
    cycle(1'b1, 4'd1, 1'b0, 1'b1);
    clk_en = 1'b0;
    repeat (3) begin
      cycle(1'b1, 4'd6, 1'b0, 1'b1);
      chk("clken frozen active", 32'(o_active), 32'd1);
      chk("clken ready_low",     32'(o_ready),  32'd0);
    end
    clk_en = 1'b1;
    cycle(1'b1, 4'd6, 1'b1, 1'b1);
    chk("clken resume mask", 32'(o_mask), 32'h0042);
    drain("clken");

    // async reset mid-frame with one entry pending
    cycle(1'b1, 4'd5, 1'b1, 1'b0);
    cycle(1'b1, 4'd2, 1'b0, 1'b0);
    chk("pre_rst valid",  32'(o_valid),  32'd1);
    chk("pre_rst active", 32'(o_active), 32'd1);
    async_reset();
    cycle(1'b1, 4'd4, 1'b1, 1'b1);
    chk("post_rst mask", 32'(o_mask), 32'h0010);
    chk("post_rst err",  32'(o_err),  32'd0);
    drain("post_rst");

    // out-of-range on the 12-wide instance
    @(negedge clk);
    sel = 1'b1;
    cycle(1'b1, 4'd13, 1'b0, 1'b1);
    cycle(1'b1, 4'd2, 1'b1, 1'b1);
    chk("oor mask",      32'(o_mask),   32'h0004);
    chk("oor err",       32'(o_err),    32'd1);
    chk("oor err_count", 32'(o_errcnt), 32'd1);
    drain("oor");

    // randomized traffic against the model
    for (int n = 0; n < 500; n++) begin
      ri = 4'($urandom_range(0, 15));
      rv = ($urandom_range(0, 3) != 0);
      rl = ($urandom_range(0, 2) == 0);
      ro = $urandom_range(0, 1) == 1;
      clk_en = ($urandom_range(0, 7) != 0);
      cycle(rv, ri, rl, ro);
    end
    clk_en = 1'b1;
    drain("rand");

    // saturation of the error counter
    for (int n = 0; n < 300; n++) begin
      cycle(1'b1, 4'd14, 1'b1, 1'b1);
    end
    chk("sat err_count", 32'(o_errcnt), 32'd255);
    drain("sat");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/onehot_decoder.md
# onehot_decoder

Streaming index-to-mask decoder; the inverse of the team's priority encoder. Accepts a stream of bit indices over a valid/ready handshake and ORs each decoded one-hot bit into an accumulator. Closes a frame on `in_last` and pushes the resulting mask into a 2-entry output FIFO. Sits between control logic that produces indices and datapath blocks that consume enable/select masks.

## Interface
- `decoderWidth`, 16: output mask width; index width is `IW = $clog2(decoderWidth)`.
- `clk` input 1: clock, rising edge.
- `rst` input 1: asynchronous, active-high reset.
- `clk_en` input 1: clock enable; when low, all state holds.
- `in_valid` input 1: input beat valid.
- `in_ready` output 1: block can accept a beat.
- `in_index` input IW: bit index to set.
- `in_last` input 1: beat closes the current frame.
- `out_valid` output 1: FIFO head holds a mask.
- `out_ready` input 1: consumer accepts the head.
- `out_mask` output decoderWidth: FIFO head mask.
- `out_err` output 1: head frame contained at least one out-of-range index.
- `err_count` output 8: saturating count of out-of-range beats.
- `frame_active` output 1: accumulator holds a partial frame.

## Operation
- Reset values:
  - `in_ready` = 0, `out_valid` = 0, `out_mask` = 0, `out_err` = 0, `err_count` = 0, `frame_active` = 0.
  - FIFO is emptied; accumulator is cleared; state is IDLE.
- Gating signals:
  - `in_ready = clk_en & (fifo_count != 2)`.
  - `out_valid = clk_en & (fifo_count != 0)`.
- Accept: `in_valid & in_ready` on a rising edge.
  - `dec` = one-hot of `in_index` if `in_index < decoderWidth`; otherwise `dec` = 0, the frame error flag is set, and `err_count` increments, saturating at 255.
- State machine (states IDLE and ACCUM):
  - IDLE, accept with `in_last=0`: `acc <= dec`, err flag latched, go to ACCUM.
  - IDLE, accept with `in_last=1`: push `{dec, err}` to the FIFO, stay in IDLE.
  - ACCUM, accept with `in_last=0`: `acc <= acc | dec`, `err_flag <= err_flag | bad`.
  - ACCUM, accept with `in_last=1`: push `{acc|dec, err_flag|bad}`, clear acc and flag, go to IDLE.
- `frame_active` = (state == ACCUM).
- Duplicate indices within a frame are idempotent (OR).
- Pop: `out_valid & out_ready` on a rising edge advances the FIFO head.
- Push and pop in the same cycle: `fifo_count` is unchanged and the order is preserved.
- A push never happens while the FIFO is full, because `in_ready` = 0 then.
- When the FIFO is full, the accumulator also stalls: no beats are accepted, last or not.
- `out_mask`/`out_err` show the head entry whenever count > 0; they read 0 when empty.
- Reset mid-frame discards the partial accumulator and all FIFO entries. No partial mask is ever emitted.

## Timing
- Latency: last beat accepted at edge N → `out_valid` high after edge N (1 cycle), provided `clk_en` is high.
- Throughput: one beat per cycle; with `out_ready` held high, one single-beat frame per cycle.
- `in_ready`/`out_valid` depend combinationally only on registered count and `clk_en`. There is no combinational path from `in_valid` or `out_ready`.
- `clk_en` low: no accept, no pop, no counter change; registered outputs hold.

## Structure
- Package `onehot_decoder_pkg`:
  - `typedef enum logic {IDLE, ACCUM} dec_state_t;`
  - `localparam ERR_CNT_W = 8;`
  - `localparam FIFO_DEPTH = 2;`
- Sub-module `mask_fifo`: 2-entry synchronous FIFO of width `decoderWidth+1`.
  - Ports: push, pop, count, head.
  - Async active-high reset; honours `clk_en`.
- Top holds the decode, the accumulator, the state machine and the error counter.

## Test plan
- Single-beat frames, width 16, `out_ready=1`:
  - Indices 0, 7, 15, each with `last=1` → masks 0x0001, 0x0080, 0x8000, each 1 cycle after accept.
  - `out_err=0` for all three.
- Multi-beat frame:
  - Indices 3, 5, 3, then 9 with last → one mask 0x0228.
  - `frame_active` high from after the first accept until the last is accepted.
- Backpressure, `out_ready=0`:
  - Three single-beat frames → `in_ready` drops after two pushes.
  - Raising `out_ready` drains 0x0002 then 0x0004, and the third frame is accepted afterwards; no loss, order preserved.
- Out-of-range, `decoderWidth=12`:
  - Indices 13, 2 with last → mask 0x004, `out_err=1`, `err_count=1`.
  - 300 bad beats → `err_count` saturates at 255.
- `clk_en` low for 3 cycles during a frame with `in_valid` held → no accept, outputs frozen; the frame resumes correctly when `clk_en` returns.
- Assert `rst` asynchronously mid-frame with 1 FIFO entry pending:
  - All outputs read 0 immediately.
  - The next frame, index 4 with last → 0x0010 with no residue.
